// File: rtl/rpn_pkg.sv
// Shared types for the RPN sequencer.
// FSM states, ALU op codes and stack pointer sizing.
package rpn_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LEER_B,
    LEER_A,
    ESCRIBIR
  } estado_e;

  typedef enum logic [1:0] {
    OP_SUMA,
    OP_RESTA,
    OP_AND,
    OP_OR
  } op_e;

  function automatic int sp_width(input int prof);
    return $clog2(prof + 1);
  endfunction

endpackage

// File: rtl/alu_generalizado.sv
// Generalized combinational ALU.
// Modulo 2^n_bits arithmetic, no flags.
module ALU_generalizado
  import rpn_pkg::*;
#(
  parameter int n_bits = 8
) (
  input  logic [n_bits-1:0] a,
  input  logic [n_bits-1:0] b,
  input  op_e               op,
  output logic [n_bits-1:0] resultado
);

  always_comb begin
    resultado = '0;
    unique case (op)
      OP_SUMA:  resultado = a + b;
      OP_RESTA: resultado = a - b;
      OP_AND:   resultado = a & b;
      OP_OR:    resultado = a | b;
    endcase
  end

endmodule

// File: rtl/rpn_controlador_pila.sv
// LIFO stack with registered top-of-stack view.
// Storage is rounded up to a power of two so sp indexes it directly.
module pila_lifo
  import rpn_pkg::*;
#(
  parameter int N_BITS = 8,
  parameter int PROF   = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      push,
  input  logic                      pop,
  input  logic                      limpiar,
  input  logic [N_BITS-1:0]         dato,
  output logic [N_BITS-1:0]         tope,
  output logic [sp_width(PROF)-1:0] profundidad,
  output logic                      lleno,
  output logic                      vacio
);

  localparam int SPW   = sp_width(PROF);
  localparam int DEPTH = 2 ** SPW;

  logic [N_BITS-1:0] mem [DEPTH];
  logic [SPW-1:0]    sp;

  assign lleno       = (sp == SPW'(PROF));
  assign vacio       = (sp == '0);
  assign profundidad = sp;
  assign tope        = vacio ? '0 : mem[sp - SPW'(1)];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sp <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (limpiar) begin
      sp <= '0;
    end else if (push && !lleno) begin
      mem[sp] <= dato;
      sp      <= sp + SPW'(1);
    end else if (pop && !vacio) begin
      sp <= sp - SPW'(1);
    end
  end

endmodule

// File: rtl/rpn_controlador.sv
// RPN sequencer: pushes operands, pops two for an ALU op,
// pushes the result back. Sticky error on over/underflow.
module rpn_controlador
  import rpn_pkg::*;
#(
  parameter int N_BITS = 8,
  parameter int PROF   = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [N_BITS-1:0]         dato_in,
  input  logic                      dato_valid,
  input  logic [1:0]                op_in,
  input  logic                      op_valid,
  input  logic                      limpiar,
  output logic                      listo,
  output logic [N_BITS-1:0]         tope,
  output logic [sp_width(PROF)-1:0] profundidad,
  output logic                      error
);

  localparam int SPW = sp_width(PROF);

  estado_e           state, next;
  op_e               op_reg;
  logic [N_BITS-1:0] reg_a, reg_b, alu_res, dato_push;
  logic              push, pop, err_set, op_load;
  logic              lleno, vacio;

  pila_lifo #(
    .N_BITS(N_BITS),
    .PROF  (PROF)
  ) u_pila (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (push),
    .pop        (pop),
    .limpiar    (limpiar),
    .dato       (dato_push),
    .tope       (tope),
    .profundidad(profundidad),
    .lleno      (lleno),
    .vacio      (vacio)
  );

  ALU_generalizado #(
    .n_bits(N_BITS)
  ) u_alu (
    .a        (reg_a),
    .b        (reg_b),
    .op       (op_reg),
    .resultado(alu_res)
  );

  assign listo = (state == IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next;
  end

  always_comb begin
    next      = state;
    push      = 1'b0;
    pop       = 1'b0;
    err_set   = 1'b0;
    op_load   = 1'b0;
    dato_push = dato_in;
    if (limpiar) begin
      next = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (dato_valid) begin
            if (lleno) err_set = 1'b1;
            else       push    = 1'b1;
          end else if (op_valid) begin
            if (profundidad >= SPW'(2)) begin
              op_load = 1'b1;
              next    = LEER_B;
            end else begin
              err_set = 1'b1;
            end
          end
        end
        LEER_B: begin
          pop  = 1'b1;
          next = LEER_A;
        end
        LEER_A: begin
          pop  = 1'b1;
          next = ESCRIBIR;
        end
        ESCRIBIR: begin
          push      = 1'b1;
          dato_push = alu_res;
          next      = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reg_a  <= '0;
      reg_b  <= '0;
      op_reg <= OP_SUMA;
      error  <= 1'b0;
    end else begin
      if (limpiar)      error <= 1'b0;
      else if (err_set) error <= 1'b1;
      if (op_load) op_reg <= op_e'(op_in);
      if (!limpiar && state == LEER_B) reg_b <= tope;
      if (!limpiar && state == LEER_A) reg_a <= tope;
    end
  end

endmodule

// File: tb/tb_rpn_controlador.sv
// Self-checking bench for rpn_controlador.
// Directed plan steps followed by a random command mix.
module tb_rpn_controlador;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] dato_in = '0;
  logic       dato_valid = 1'b0;
  logic [1:0] op_in = '0;
  logic       op_valid = 1'b0;
  logic       limpiar = 1'b0;
  logic       listo;
  logic [7:0] tope;
  logic [2:0] profundidad;
  logic       error;

  int total = 0;
  int bad = 0;
  int q[$];
  bit m_err = 1'b0;

  always #5 clk = ~clk;

  rpn_controlador #(.N_BITS(8), .PROF(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .dato_in    (dato_in),
    .dato_valid (dato_valid),
    .op_in      (op_in),
    .op_valid   (op_valid),
    .limpiar    (limpiar),
    .listo      (listo),
    .tope       (tope),
    .profundidad(profundidad),
    .error      (error)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int exp_top;
    exp_top = (q.size() > 0) ? q[$] : 0;
    chk({tag, ".tope"}, int'(tope), exp_top);
    chk({tag, ".prof"}, int'(profundidad), q.size());
    chk({tag, ".error"}, int'(error), int'(m_err));
    chk({tag, ".listo"}, int'(listo), 1);
  endtask

  task automatic push(input int v);
    @(negedge clk);
    dato_in = 8'(v);
    dato_valid = 1'b1;
    @(negedge clk);
    dato_valid = 1'b0;
    if (q.size() == 4) m_err = 1'b1;
    else q.push_back(v & 8'hFF);
  endtask

  task automatic do_op(input int o, input string tag);
    int cnt, a, b, r;
    @(negedge clk);
    op_in = 2'(o);
    op_valid = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
    cnt = 0;
    while (!listo && cnt < 10) begin
      cnt++;
      @(negedge clk);
    end
    if (q.size() < 2) begin
      m_err = 1'b1;
      chk({tag, ".lat"}, cnt, 0);
    end else begin
      chk({tag, ".lat"}, cnt, 3);
      b = q.pop_back();
      a = q.pop_back();
      case (o)
        0: r = (a + b) & 8'hFF;
        1: r = (a - b) & 8'hFF;
        2: r = a & b;
        default: r = a | b;
      endcase
      q.push_back(r);
    end
  endtask

  task automatic clr();
    @(negedge clk);
    limpiar = 1'b1;
    @(negedge clk);
    limpiar = 1'b0;
    q.delete();
    m_err = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_all("reset");

    push(5); push(3); do_op(1, "sub52");
    check_all("sub52");
    chk("sub52.val", int'(tope), 2);
    clr();
    push(3); push(5); do_op(1, "subfe");
    chk("subfe.val", int'(tope), 8'hFE);
    check_all("subfe");
    clr();

    push(8'hFF); push(2); do_op(0, "wrap");
    chk("wrap.val", int'(tope), 1);
    push(8'h0C); push(3); do_op(3, "or");
    chk("or.val", int'(tope), 8'h0F);
    check_all("or");
    clr();

    push(7); do_op(0, "under");
    check_all("under");
    chk("under.flag", int'(error), 1);
    clr();

    for (int i = 1; i <= 5; i++) push(i);
    check_all("over");
    chk("over.flag", int'(error), 1);
    chk("over.top", int'(tope), 4);
    clr();
    check_all("clr");

    push(1); push(2);
    @(negedge clk);
    dato_in = 8'd9;
    dato_valid = 1'b1;
    op_in = 2'b00;
    op_valid = 1'b1;
    @(negedge clk);
    dato_valid = 1'b0;
    op_valid = 1'b0;
    q.push_back(9);
    check_all("both");
    chk("both.prof", int'(profundidad), 3);
    clr();

    push(10); push(20);
    @(negedge clk);
    op_in = 2'b00;
    op_valid = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    limpiar = 1'b1;
    @(negedge clk);
    limpiar = 1'b0;
    q.delete();
    m_err = 1'b0;
    check_all("abort");
    @(negedge clk);
    check_all("abort2");

    push(4); push(6);
    @(negedge clk);
    op_in = 2'b00;
    op_valid = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    q.delete();
    m_err = 1'b0;
    check_all("async");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_all("postrst");

    for (int i = 0; i < 80; i++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel < 5) push(int'($urandom_range(0, 255)));
      else if (sel < 9) do_op(int'($urandom_range(0, 3)), "rnd");
      else clr();
      check_all("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
